// File: rtl/mem_port_arbiter_if.sv
// Bus bundle for mem_port_arbiter: fetch port, EXE data port and the shared
// single-ported RAM. Field names mirror the arbiter's port list.
//   slave  : the arbiter's view (takes requests and RAM read data, drives
//            grants, responses and RAM controls).
//   master : the surrounding system's view (pipeline masters plus the RAM).
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32
);
  // fetch port
  logic              inst_req;
  logic [ADDR_W-1:0] inst_addr;
  logic              inst_gnt;
  logic              inst_rvalid;
  logic [31:0]       inst_rdata;
  // data port
  logic              data_req;
  logic [ADDR_W-1:0] data_addr;
  logic [3:0]        data_we;
  logic [31:0]       data_wdata;
  logic              data_gnt;
  logic              data_rvalid;
  logic [31:0]       data_rdata;
  // RAM side
  logic              ram_en;
  logic [3:0]        ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [31:0]       ram_wdata;
  logic [31:0]       ram_rdata;

  modport slave (
    input  inst_req, inst_addr,
    input  data_req, data_addr, data_we, data_wdata,
    input  ram_rdata,
    output inst_gnt, inst_rvalid, inst_rdata,
    output data_gnt, data_rvalid, data_rdata,
    output ram_en, ram_we, ram_addr, ram_wdata
  );

  modport master (
    output inst_req, inst_addr,
    output data_req, data_addr, data_we, data_wdata,
    output ram_rdata,
    input  inst_gnt, inst_rvalid, inst_rdata,
    input  data_gnt, data_rvalid, data_rdata,
    input  ram_en, ram_we, ram_addr, ram_wdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one single-ported synchronous RAM between instruction fetch and the
// EXE data port. Data wins ties unless fetch has been denied STARVE_LIMIT
// cycles in a row, in which case fetch is forced through. Read data returns
// one cycle after the grant and is steered to the master that issued it.
// Ports:
//   clk    : clock
//   reset  : synchronous, active-high
//   bus    : mem_port_arbiter_if.slave
//            inst_req/addr -> inst_gnt, inst_rvalid, inst_rdata
//            data_req/addr/we/wdata -> data_gnt, data_rvalid, data_rdata
//            ram_en/we/addr/wdata out, ram_rdata in
module mem_port_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int STARVE_LIMIT = 4   // 1..15
) (
  input  logic               clk,
  input  logic               reset,
  mem_port_arbiter_if.slave  bus
);
  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_INST = 2'd1,
    OWN_DATA = 2'd2
  } owner_e;

  logic [3:0]        starve_cnt;
  owner_e            resp_owner;
  logic              force_fetch;
  logic              inst_win;
  logic              data_win;
  logic [ADDR_W-1:0] sel_addr;

  // Grant decision is purely combinational so a request can win the same
  // cycle it is raised. Reset blocks both grants so nothing touches the RAM.
  always_comb begin
    force_fetch = (starve_cnt == LIMIT);
    inst_win    = !reset && bus.inst_req && (!bus.data_req || force_fetch);
    data_win    = !reset && bus.data_req && !inst_win;
    sel_addr    = inst_win ? bus.inst_addr : bus.data_addr;
  end

  assign bus.inst_gnt  = inst_win;
  assign bus.data_gnt  = data_win;
  assign bus.ram_en    = inst_win | data_win;
  assign bus.ram_addr  = sel_addr;
  // fetch is read-only; only a data grant may carry byte enables
  assign bus.ram_we    = data_win ? bus.data_we : 4'b0000;
  assign bus.ram_wdata = bus.data_wdata;

  // RAM read data is shared; each rvalid qualifies its own copy.
  assign bus.inst_rdata = bus.ram_rdata;
  assign bus.data_rdata = bus.ram_rdata;

  // Gating with reset drops a response whose grant came just before reset.
  assign bus.inst_rvalid = !reset && (resp_owner == OWN_INST);
  assign bus.data_rvalid = !reset && (resp_owner == OWN_DATA);

  always_ff @(posedge clk) begin
    if (reset) begin
      starve_cnt <= 4'd0;
      resp_owner <= OWN_NONE;
    end else begin
      // Count only cycles where fetch is waiting and losing; any grant or
      // idle fetch restarts the count.
      if (bus.inst_req && !inst_win)
        starve_cnt <= (starve_cnt == LIMIT) ? LIMIT : starve_cnt + 4'd1;
      else
        starve_cnt <= 4'd0;

      // Writes complete at grant, so they leave no response pending.
      if (inst_win)
        resp_owner <= OWN_INST;
      else if (data_win && (bus.data_we == 4'b0000))
        resp_owner <= OWN_DATA;
      else
        resp_owner <= OWN_NONE;
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;
  localparam int LIMIT = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(32)) bus ();

  mem_port_arbiter #(.ADDR_W(32), .STARVE_LIMIT(LIMIT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] init_word(input int i);
    logic [7:0] b;
    b = i[7:0];
    return {8'hC0, b, ~b, b};
  endfunction

  // RAM driven by the DUT, and a separate reference copy owned by the model.
  logic [31:0] ram     [256];
  logic [31:0] ref_mem [256];
  initial for (int i = 0; i < 256; i++) begin
    ram[i]     = init_word(i);
    ref_mem[i] = init_word(i);
  end

  always @(posedge clk) begin
    if (bus.ram_en) begin
      if (bus.ram_we == 4'b0000)
        bus.ram_rdata <= ram[bus.ram_addr[9:2]];
      else
        for (int b = 0; b < 4; b++)
          if (bus.ram_we[b]) ram[bus.ram_addr[9:2]][8*b +: 8] <= bus.ram_wdata[8*b +: 8];
    end
  end

  // Reference model: who should win this cycle, and what is owed next cycle.
  int          m_starve = 0;
  int          m_pend   = 0;   // 0 none, 1 fetch, 2 data
  logic [31:0] m_word   = '0;

  always @(negedge clk) begin
    int win;
    logic [7:0] idx;
    win = 0;
    if (!reset) begin
      if (bus.inst_req && bus.data_req) win = (m_starve >= LIMIT) ? 1 : 2;
      else if (bus.inst_req)            win = 1;
      else if (bus.data_req)            win = 2;
    end
    chk("inst_gnt", bus.inst_gnt, win == 1);
    chk("data_gnt", bus.data_gnt, win == 2);
    chk("ram_en",   bus.ram_en,   win != 0);
    chk("ram_we",   bus.ram_we,   (win == 2) ? bus.data_we : 4'b0000);
    if (win == 1) chk("ram_addr_i", bus.ram_addr, bus.inst_addr);
    if (win == 2) chk("ram_addr_d", bus.ram_addr, bus.data_addr);
    if (win == 2 && bus.data_we != 0) chk("ram_wdata", bus.ram_wdata, bus.data_wdata);
    chk("inst_rvalid", bus.inst_rvalid, !reset && m_pend == 1);
    chk("data_rvalid", bus.data_rvalid, !reset && m_pend == 2);
    if (!reset && m_pend == 1) chk("inst_rdata", bus.inst_rdata, m_word);
    if (!reset && m_pend == 2) chk("data_rdata", bus.data_rdata, m_word);

    // advance to the next cycle
    m_pend = 0;
    if (win == 1) begin
      m_pend = 1;
      m_word = ref_mem[bus.inst_addr[9:2]];
    end else if (win == 2) begin
      idx = bus.data_addr[9:2];
      if (bus.data_we == 0) begin
        m_pend = 2;
        m_word = ref_mem[idx];
      end else begin
        for (int b = 0; b < 4; b++)
          if (bus.data_we[b]) ref_mem[idx][8*b +: 8] = bus.data_wdata[8*b +: 8];
      end
    end
    if (reset)                          m_starve = 0;
    else if (bus.inst_req && win != 1)  m_starve = (m_starve + 1 > LIMIT) ? LIMIT : m_starve + 1;
    else                                m_starve = 0;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset          = 1'b1;
    bus.inst_req   = 1'b1;   // requests during reset must not be granted
    bus.inst_addr  = 32'h100;
    bus.data_req   = 1'b1;
    bus.data_addr  = 32'h200;
    bus.data_we    = 4'b0000;
    bus.data_wdata = 32'h0;

    @(negedge clk);
    chk("rst_inst_gnt", bus.inst_gnt, 1'b0);
    chk("rst_data_gnt", bus.data_gnt, 1'b0);
    chk("rst_ram_en",   bus.ram_en,   1'b0);
    step(); step();
    reset = 1'b0; bus.inst_req = 1'b0; bus.data_req = 1'b0;
    @(negedge clk);
    chk("post_rst_irv", bus.inst_rvalid, 1'b0);
    chk("post_rst_drv", bus.data_rvalid, 1'b0);
    chk("post_rst_cnt", dut.starve_cnt, 4'd0);
    step();

    // fetch only
    bus.inst_req = 1'b1; bus.inst_addr = 32'h100;
    @(negedge clk);
    chk("f_gnt",  bus.inst_gnt, 1'b1);
    chk("f_addr", bus.ram_addr, 32'h100);
    chk("f_we",   bus.ram_we,   4'b0000);
    step();
    bus.inst_req = 1'b0;
    @(negedge clk);
    chk("f_rvalid", bus.inst_rvalid, 1'b1);
    chk("f_rdata",  bus.inst_rdata,  32'hC040BF40);
    chk("f_drv",    bus.data_rvalid, 1'b0);
    step();

    // conflict: data wins, fetch follows
    bus.inst_req = 1'b1; bus.inst_addr = 32'h104;
    bus.data_req = 1'b1; bus.data_addr = 32'h200; bus.data_we = 4'b0000;
    @(negedge clk);
    chk("c_dgnt", bus.data_gnt, 1'b1);
    chk("c_ignt", bus.inst_gnt, 1'b0);
    chk("c_addr", bus.ram_addr, 32'h200);
    step();
    bus.data_req = 1'b0;
    @(negedge clk);
    chk("c_drv",   bus.data_rvalid, 1'b1);
    chk("c_rdata", bus.data_rdata,  32'hC0807F80);
    chk("c_ignt2", bus.inst_gnt,    1'b1);
    step();
    bus.inst_req = 1'b0;

    // store, then read it back
    bus.data_req = 1'b1; bus.data_addr = 32'h302;
    bus.data_we = 4'b0100; bus.data_wdata = 32'h00AB0000;
    @(negedge clk);
    chk("s_we",    bus.ram_we,    4'b0100);
    chk("s_wdata", bus.ram_wdata, 32'h00AB0000);
    step();
    bus.data_req = 1'b0; bus.data_we = 4'b0000;
    @(negedge clk);
    chk("s_no_drv", bus.data_rvalid, 1'b0);
    chk("s_no_irv", bus.inst_rvalid, 1'b0);
    step();
    bus.data_req = 1'b1; bus.data_addr = 32'h300;
    step();
    bus.data_req = 1'b0;
    @(negedge clk);
    chk("s_readback", bus.data_rdata, 32'hC0AB3FC0);
    step();

    // starvation: continuous data reads with fetch waiting
    bus.inst_req = 1'b1; bus.inst_addr = 32'h108;
    bus.data_req = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      bus.data_addr = 32'h10C + 32'(4 * k);
      @(negedge clk);
      if (k == 5 || k == 10) begin
        chk("st_ignt", bus.inst_gnt, 1'b1);
        chk("st_dgnt", bus.data_gnt, 1'b0);
      end
      if (k == 4) chk("st_ignt_early", bus.inst_gnt, 1'b0);
      if (k == 6) chk("st_cnt_clr", dut.starve_cnt, 4'd0);
      step();
    end
    bus.inst_req = 1'b0; bus.data_req = 1'b0;
    step();

    // back-to-back: fetch at N, data read at N+1
    bus.inst_req = 1'b1; bus.inst_addr = 32'h100;
    step();
    bus.inst_req = 1'b0;
    bus.data_req = 1'b1; bus.data_addr = 32'h200;
    @(negedge clk);
    chk("bb_irv1", bus.inst_rvalid, 1'b1);
    chk("bb_drv1", bus.data_rvalid, 1'b0);
    step();
    bus.data_req = 1'b0;
    @(negedge clk);
    chk("bb_irv2", bus.inst_rvalid, 1'b0);
    chk("bb_drv2", bus.data_rvalid, 1'b1);
    step();

    // reset right after a read grant
    bus.data_req = 1'b1; bus.data_addr = 32'h200;
    step();
    bus.data_req = 1'b0; reset = 1'b1;
    @(negedge clk);
    chk("rm_drv",    bus.data_rvalid, 1'b0);
    chk("rm_ram_en", bus.ram_en,      1'b0);
    chk("rm_ram_we", bus.ram_we,      4'b0000);
    step();
    reset = 1'b0;
    bus.inst_req = 1'b1; bus.inst_addr = 32'h104;
    @(negedge clk);
    chk("rm_drv_after", bus.data_rvalid, 1'b0);
    chk("rm_ignt",      bus.inst_gnt,    1'b1);
    step();
    bus.inst_req = 1'b0;
    @(negedge clk);
    chk("rm_irv",   bus.inst_rvalid, 1'b1);
    chk("rm_rdata", bus.inst_rdata,  32'hC041BE41);
    step(); step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
